// File: rtl/song_reader_pkg.sv
// Shared definitions for the song sequencer: widths, ROM word layout and
// the sequencer state encoding.
package song_reader_pkg;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int SONG_W = 2;
  localparam int IDX_W  = 5;

  // ROM word is {note, duration}
  localparam int DUR_LSB  = 0;
  localparam int NOTE_LSB = DUR_W;

  localparam int TERMINATOR_DUR = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DATA,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

endpackage

// File: rtl/song_reader.sv
// Walks one song's note list in the external song ROM, hands each note to the
// note player with a load strobe, and waits for the player before moving on.
module song_reader #(
  parameter int NOTE_W = song_reader_pkg::NOTE_W,
  parameter int DUR_W  = song_reader_pkg::DUR_W,
  parameter int SONG_W = song_reader_pkg::SONG_W,
  parameter int IDX_W  = song_reader_pkg::IDX_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      play,
  input  logic [SONG_W-1:0]         song,
  input  logic                      note_done,
  output logic [SONG_W+IDX_W-1:0]   rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  output logic                      new_note,
  output logic                      song_done
);
  import song_reader_pkg::*;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [SONG_W-1:0]         song_q, song_d;
  logic                      play_q;
  logic [SONG_W+IDX_W-1:0]   rom_addr_q;
  logic [NOTE_W-1:0]         note_q;
  logic [DUR_W-1:0]          dur_q;
  logic                      capture;

  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic              play_rise;
  logic              song_change;

  assign rom_note  = rom_data[NOTE_LSB +: NOTE_W];
  assign rom_dur   = rom_data[DUR_LSB +: DUR_W];
  assign play_rise = play & ~play_q;
  // A new selection mid-song restarts from its first note; IDLE tracks song anyway
  assign song_change = (song != song_q) && (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    song_d  = song_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        song_d = song;
        if (play_rise) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DATA;
      S_DATA: begin
        capture = 1'b1;
        state_d = (rom_dur == DUR_W'(TERMINATOR_DUR)) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (play) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (note_done && play) begin
          if (&idx_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (song_change) begin
      idx_d   = '0;
      song_d  = song;
      capture = 1'b0;
      state_d = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      song_q  <= '0;
      play_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      song_q  <= song_d;
      play_q  <= play;
    end
  end

  // Address is loaded on entry to FETCH so the synchronous ROM answers in DATA
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      note_q     <= '0;
      dur_q      <= '0;
    end else begin
      if (state_d == S_FETCH) rom_addr_q <= {song_d, idx_d};
      if (capture) begin
        note_q <= rom_note;
        dur_q  <= rom_dur;
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  assign note      = note_q;
  assign duration  = dur_q;
  assign new_note  = (state_q == S_LOAD) && play;
  assign song_done = (state_q == S_DONE);

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader with a behavioural synchronous song ROM and
// a scoreboard of expected note loads.
module tb_song_reader;
  import song_reader_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        play;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;

  logic [11:0] rom [0:127];
  logic [11:0] sb [$];
  logic [11:0] obs_q [$];
  int          obs_rd;
  int          checks;
  int          errors;
  int          n0;

  song_reader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .play      (play),
    .song      (song),
    .note_done (note_done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note      (note),
    .duration  (duration),
    .new_note  (new_note),
    .song_done (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(negedge clk) begin
    if (new_note) obs_q.push_back({note, duration});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_load(input string tag, input logic [11:0] w);
    chk({tag, "_strobe"}, 32'(new_note), 32'd1);
    chk({tag, "_note"}, 32'(note), 32'(w[11:6]));
    chk({tag, "_dur"}, 32'(duration), 32'(w[5:0]));
  endtask

  // From IDLE: play rise in cycle 0, FETCH in cycle 1, load strobe in cycle 3.
  task automatic start_song(input logic [11:0] w, input logic [6:0] a);
    play = 1'b0;
    step(1);
    sb.push_back(w);
    play = 1'b1;
    step(1);
    chk("start_addr", 32'(rom_addr), 32'(a));
    step(2);
    chk_load("start", w);
  endtask

  // From LOAD/PLAY: note_done in PLAY cycle n, FETCH n+1, load strobe n+3.
  task automatic next_note(input logic [11:0] w, input logic [6:0] a);
    step(1);
    note_done = 1'b1;
    sb.push_back(w);
    step(1);
    note_done = 1'b0;
    chk("next_addr", 32'(rom_addr), 32'(a));
    step(2);
    chk_load("next", w);
  endtask

  // Next word is a terminator: DONE three cycles after note_done.
  task automatic finish_term();
    step(1);
    note_done = 1'b1;
    step(1);
    note_done = 1'b0;
    step(2);
    chk("term_done", 32'(song_done), 32'd1);
    chk("term_no_load", 32'(new_note), 32'd0);
    step(1);
    chk("term_done_pulse", 32'(song_done), 32'd0);
    chk("term_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("term_idx", 32'(dut.idx_q), 32'd0);
  endtask

  task automatic drain(input string tag);
    step(1);
    chk({tag, "_count"}, 32'(obs_q.size() - obs_rd), 32'(sb.size()));
    while (sb.size() > 0 && obs_rd < obs_q.size()) begin
      chk({tag, "_word"}, 32'(obs_q[obs_rd]), 32'(sb.pop_front()));
      obs_rd++;
    end
    sb.delete();
    obs_rd = obs_q.size();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    obs_rd = 0;
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[0] = {6'd20, 6'd5};
    rom[1] = {6'd33, 6'd7};
    rom[2] = {6'd45, 6'd0};
    for (int i = 0; i < 6; i++) rom[32 + i] = {6'(10 + i), 6'(2 + i)};
    rom[64] = {6'd9, 6'd3};
    rom[65] = {6'd17, 6'd0};
    for (int i = 0; i < 32; i++) rom[96 + i] = {6'(i + 1), 6'(63 - i)};

    reset_n   = 1'b0;
    play      = 1'b0;
    song      = 2'd0;
    note_done = 1'b0;
    step(2);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_note", 32'(note), 32'd0);
    chk("rst_dur", 32'(duration), 32'd0);
    chk("rst_new_note", 32'(new_note), 32'd0);
    chk("rst_song_done", 32'(song_done), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
    reset_n = 1'b1;
    step(2);

    // Basic two-note song ending on a terminator
    start_song(rom[0], 7'd0);
    next_note(rom[1], 7'd1);
    finish_term();
    drain("basic");

    // Pause in PLAY: note_done ignored, nothing fetched until play returns
    start_song(rom[0], 7'd0);
    step(1);
    play      = 1'b0;
    note_done = 1'b1;
    step(1);
    note_done = 1'b0;
    step(2);
    chk("pause_state", 32'(dut.state_q), 32'(S_PLAY));
    chk("pause_addr", 32'(rom_addr), 32'd0);
    play = 1'b1;
    step(2);
    chk("resume_state", 32'(dut.state_q), 32'(S_PLAY));
    next_note(rom[1], 7'd1);
    finish_term();
    drain("pause");

    // Song change 1->2 while playing idx 4
    song = 2'd1;
    start_song(rom[32], 7'd32);
    for (int i = 1; i < 5; i++) next_note(rom[32 + i], 7'(32 + i));
    step(1);
    chk("chg_idx", 32'(dut.idx_q), 32'd4);
    song = 2'd2;
    sb.push_back(rom[64]);
    step(1);
    chk("chg_addr", 32'(rom_addr), 32'h40);
    step(2);
    chk_load("chg", rom[64]);
    finish_term();
    drain("change");

    // Full 32-note song with no terminator
    song = 2'd3;
    start_song(rom[96], 7'd96);
    for (int i = 1; i < 32; i++) next_note(rom[96 + i], 7'(96 + i));
    step(1);
    note_done = 1'b1;
    step(1);
    note_done = 1'b0;
    chk("full_done", 32'(song_done), 32'd1);
    step(1);
    chk("full_done_pulse", 32'(song_done), 32'd0);
    chk("full_state", 32'(dut.state_q), 32'(S_IDLE));
    drain("full");

    // Async reset mid-song, then silence until play rises again
    start_song(rom[96], 7'd96);
    next_note(rom[97], 7'd97);
    step(1);
    reset_n = 1'b0;
    play    = 1'b0;
    #1;
    chk("mid_rst_note", 32'(note), 32'd0);
    chk("mid_rst_dur", 32'(duration), 32'd0);
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(S_IDLE));
    step(2);
    reset_n = 1'b1;
    n0 = obs_q.size();
    step(6);
    chk("mid_rst_quiet", 32'(obs_q.size()), 32'(n0));
    chk("mid_rst_no_done", 32'(song_done), 32'd0);
    chk("mid_rst_idle", 32'(dut.state_q), 32'(S_IDLE));
    drain("reset");
    start_song(rom[96], 7'd96);
    drain("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
